// File: rtl/aes_em_pkg.sv
// ---------------------------------------------------------------------------
// Module   : aes_em_pkg
// Brief    : Shared alarm-handler state encoding and response defaults.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aes_em_pkg;

    localparam int ZERO_CYCLES_DEF = 8;
    localparam int LOCK_THRESH_DEF = 3;
    localparam int TIMER_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_ZEROIZE = 3'd2,
        ST_HOLD    = 3'd3,
        ST_LOCKED  = 3'd4
    } alarm_state_e;

endpackage : aes_em_pkg

`default_nettype wire

// File: rtl/aes_alarm_counter.sv
// ---------------------------------------------------------------------------
// Module   : aes_alarm_counter
// Brief    : Saturating fault-event counter.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_alarm_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : aes_alarm_counter

`default_nettype wire

// File: rtl/aes_alarm_handler.sv
// ---------------------------------------------------------------------------
// Module   : aes_alarm_handler
// Brief    : Fault-sensor alarm collector and zeroize/halt/lockout response FSM.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_alarm_handler
    import aes_em_pkg::*;
#(
    parameter int N_SENSORS   = 16,
    parameter int ZERO_CYCLES = ZERO_CYCLES_DEF,
    parameter int CNT_W       = 4,
    parameter int LOCK_THRESH = LOCK_THRESH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SENSORS-1:0] alarm_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    output logic                 zeroize_o,
    output logic                 halt_o,
    output logic                 irq_o,
    output logic                 locked_o,
    output logic [N_SENSORS-1:0] status_o,
    output logic [CNT_W-1:0]     fault_cnt_o
);

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(ZERO_CYCLES - 1);
    localparam bit                 LOCK_EN    = (LOCK_THRESH != 0);

    alarm_state_e         state_q, state_d;
    logic [N_SENSORS-1:0] status_q, status_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 zeroize_q, halt_q, irq_q, locked_q;
    logic                 cnt_inc;
    logic [CNT_W-1:0]     fault_cnt;
    logic                 any_alarm;
    logic                 lock_hit;

    assign any_alarm = |alarm_i;
    // The count already includes the event being zeroized, so compare it directly.
    assign lock_hit  = LOCK_EN && (32'(fault_cnt) >= 32'(LOCK_THRESH));

    aes_alarm_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (cnt_inc),
        .cnt_o (fault_cnt)
    );

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        timer_d  = timer_q;
        cnt_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (any_alarm) begin
                    status_d = status_q | alarm_i;
                    cnt_inc  = 1'b1;
                    timer_d  = TIMER_LOAD;
                    state_d  = ST_ZEROIZE;
                end else if (!enable_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ZEROIZE: begin
                status_d = status_q | alarm_i;
                if (timer_q == '0) begin
                    state_d = lock_hit ? ST_LOCKED : ST_HOLD;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_HOLD: begin
                if (clear_i && any_alarm) begin
                    status_d = alarm_i;
                    cnt_inc  = 1'b1;
                    timer_d  = TIMER_LOAD;
                    state_d  = ST_ZEROIZE;
                end else if (clear_i) begin
                    status_d = '0;
                    state_d  = ST_ARMED;
                end else begin
                    status_d = status_q | alarm_i;
                end
            end
            ST_LOCKED: begin
                status_d = status_q | alarm_i;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear on the same edge as the transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            status_q  <= '0;
            timer_q   <= '0;
            zeroize_q <= 1'b0;
            halt_q    <= 1'b0;
            irq_q     <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            timer_q   <= timer_d;
            zeroize_q <= (state_d == ST_ZEROIZE);
            halt_q    <= (state_d == ST_ZEROIZE) || (state_d == ST_HOLD) || (state_d == ST_LOCKED);
            irq_q     <= (state_d == ST_HOLD) || (state_d == ST_LOCKED);
            locked_q  <= (state_d == ST_LOCKED);
        end
    end

    assign zeroize_o   = zeroize_q;
    assign halt_o      = halt_q;
    assign irq_o       = irq_q;
    assign locked_o    = locked_q;
    assign status_o    = status_q;
    assign fault_cnt_o = fault_cnt;

endmodule : aes_alarm_handler

`default_nettype wire

// File: tb/tb_aes_alarm_handler.sv
// ---------------------------------------------------------------------------
// Module   : tb_aes_alarm_handler
// Brief    : Self-checking bench for two alarm-handler configurations.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aes_alarm_handler;

    localparam int ZC = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] alarm;
    logic        enable;
    logic        clear;

    logic        z_a, h_a, i_a, l_a;
    logic [15:0] s_a;
    logic [3:0]  c_a;
    logic        z_b, h_b, i_b, l_b;
    logic [15:0] s_b;
    logic [1:0]  c_b;

    int n_cmp = 0;
    int n_err = 0;
    int zcount = 0;

    // Reference state: [0] default config, [1] CNT_W=2 / lockout disabled
    int          m_zleft [2] = '{0, 0};
    bit          m_wait  [2] = '{0, 0};
    bit          m_lock  [2] = '{0, 0};
    bit          m_armed [2] = '{0, 0};
    logic [15:0] m_stat  [2] = '{16'h0, 16'h0};
    int          m_cnt   [2] = '{0, 0};
    int          CMAX    [2] = '{15, 3};
    int          LTH     [2] = '{3, 0};

    aes_alarm_handler dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .alarm_i     (alarm),
        .enable_i    (enable),
        .clear_i     (clear),
        .zeroize_o   (z_a),
        .halt_o      (h_a),
        .irq_o       (i_a),
        .locked_o    (l_a),
        .status_o    (s_a),
        .fault_cnt_o (c_a)
    );

    aes_alarm_handler #(
        .N_SENSORS   (16),
        .ZERO_CYCLES (ZC),
        .CNT_W       (2),
        .LOCK_THRESH (0)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .alarm_i     (alarm),
        .enable_i    (enable),
        .clear_i     (clear),
        .zeroize_o   (z_b),
        .halt_o      (h_b),
        .irq_o       (i_b),
        .locked_o    (l_b),
        .status_o    (s_b),
        .fault_cnt_o (c_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [15:0] a, input logic en, input logic clr, input logic rn);
        for (int i = 0; i < 2; i++) begin
            if (!rn) begin
                m_zleft[i] = 0; m_wait[i] = 0; m_lock[i] = 0;
                m_armed[i] = 0; m_stat[i] = '0; m_cnt[i]  = 0;
            end else if (m_zleft[i] > 0) begin
                m_stat[i]  = m_stat[i] | a;
                m_zleft[i] = m_zleft[i] - 1;
                if (m_zleft[i] == 0) begin
                    if (LTH[i] != 0 && m_cnt[i] >= LTH[i]) m_lock[i] = 1;
                    else                                  m_wait[i] = 1;
                end
            end else if (m_lock[i]) begin
                m_stat[i] = m_stat[i] | a;
            end else if (m_wait[i]) begin
                if (clr && a != 0) begin
                    m_stat[i]  = a;
                    m_cnt[i]   = (m_cnt[i] < CMAX[i]) ? m_cnt[i] + 1 : CMAX[i];
                    m_zleft[i] = ZC;
                    m_wait[i]  = 0;
                end else if (clr) begin
                    m_stat[i]  = '0;
                    m_wait[i]  = 0;
                    m_armed[i] = 1;
                end else begin
                    m_stat[i] = m_stat[i] | a;
                end
            end else if (m_armed[i]) begin
                if (a != 0) begin
                    m_stat[i]  = m_stat[i] | a;
                    m_cnt[i]   = (m_cnt[i] < CMAX[i]) ? m_cnt[i] + 1 : CMAX[i];
                    m_zleft[i] = ZC;
                end else if (!en) begin
                    m_armed[i] = 0;
                end
            end else if (en) begin
                m_armed[i] = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("a_zeroize", 32'(z_a), 32'(m_zleft[0] > 0));
        chk("a_halt",    32'(h_a), 32'(m_zleft[0] > 0 || m_wait[0] || m_lock[0]));
        chk("a_irq",     32'(i_a), 32'(m_wait[0] || m_lock[0]));
        chk("a_locked",  32'(l_a), 32'(m_lock[0]));
        chk("a_status",  32'(s_a), 32'(m_stat[0]));
        chk("a_cnt",     32'(c_a), 32'(m_cnt[0]));
        chk("b_zeroize", 32'(z_b), 32'(m_zleft[1] > 0));
        chk("b_halt",    32'(h_b), 32'(m_zleft[1] > 0 || m_wait[1] || m_lock[1]));
        chk("b_irq",     32'(i_b), 32'(m_wait[1] || m_lock[1]));
        chk("b_locked",  32'(l_b), 32'(m_lock[1]));
        chk("b_status",  32'(s_b), 32'(m_stat[1]));
        chk("b_cnt",     32'(c_b), 32'(m_cnt[1]));
    endtask

    task automatic step(input logic [15:0] a, input logic en, input logic clr, input logic rn);
        @(negedge clk);
        alarm  = a;
        enable = en;
        clear  = clr;
        rst_n  = rn;
        @(posedge clk);
        model_edge(a, en, clr, rn);
        #1;
        if (z_a) zcount++;
        check_all();
    endtask

    initial begin
        alarm = '0; enable = 1'b0; clear = 1'b0; rst_n = 1'b0;

        step(16'h0, 0, 0, 0);
        step(16'h0, 0, 0, 0);
        chk("rst_status", 32'(s_a), 32'h0);

        // First event: zeroize window, status and count
        step(16'h0, 1, 0, 1);
        zcount = 0;
        step(16'h0004, 1, 0, 1);
        chk("ev1_zeroize", 32'(z_a), 32'h1);
        chk("ev1_status",  32'(s_a), 32'h0004);
        chk("ev1_cnt",     32'(c_a), 32'h1);
        step(16'h0, 1, 0, 1);
        step(16'h8000, 1, 0, 1);
        chk("zz_status", 32'(s_a), 32'h8004);
        chk("zz_cnt",    32'(c_a), 32'h1);
        repeat (10) step(16'h0, 1, 0, 1);
        chk("ev1_zlen", 32'(zcount), 32'(ZC));
        chk("hold_irq", 32'(i_a), 32'h1);
        step(16'h0, 1, 1, 1);
        chk("clr_status", 32'(s_a), 32'h0);
        chk("clr_halt",   32'(h_a), 32'h0);
        chk("clr_cnt",    32'(c_a), 32'h1);

        // Second event, then clear+alarm in HOLD forms the third
        step(16'h0020, 1, 0, 1);
        repeat (10) step(16'h0, 1, 0, 1);
        zcount = 0;
        step(16'h0010, 1, 1, 1);
        chk("ca_status", 32'(s_a), 32'h0010);
        chk("ca_cnt",    32'(c_a), 32'h3);
        repeat (10) step(16'h0, 1, 0, 1);
        chk("ev3_zlen",  32'(zcount), 32'(ZC));
        chk("lock_a",    32'(l_a), 32'h1);
        step(16'h0, 1, 1, 1);
        chk("lock_hold", 32'(l_a), 32'h1);
        step(16'h0, 0, 0, 0);
        chk("lock_rst",  32'(l_a), 32'h0);

        // IDLE ignores alarms
        step(16'h0, 0, 0, 1);
        step(16'hFFFF, 0, 0, 1);
        step(16'h0, 0, 0, 1);
        chk("idle_status",  32'(s_a), 32'h0);
        chk("idle_zeroize", 32'(z_a), 32'h0);

        // Five events: narrow counter saturates, no lockout on the disabled config
        for (int k = 0; k < 5; k++) begin
            step(16'h0, 1, 0, 1);
            step(16'(1) << k, 1, 0, 1);
            repeat (9) step(16'h0, 1, 0, 1);
            step(16'h0, 1, 1, 1);
        end
        chk("sat_cnt_b",    32'(c_b), 32'h3);
        chk("sat_locked_b", 32'(l_b), 32'h0);

        // Randomized run against the reference model
        step(16'h0, 0, 0, 0);
        for (int n = 0; n < 1500; n++) begin
            logic [15:0] ra;
            ra = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
            step(ra, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 199) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_aes_alarm_handler

`default_nettype wire
